// File: rtl/mul_ctrl_pkg.sv
// Shared types and constants for the RV32M multiply sequencer: bus widths,
// funct3 encodings, FSM state encoding and the operand-magnitude helper.
package mul_ctrl_pkg;

   localparam int DATA_BUS_WIDTH        = 32;
   localparam int DOUBLE_DATA_BUS_WIDTH = 2 * DATA_BUS_WIDTH;

   localparam logic [2:0] FUNCT3_MUL    = 3'b000;
   localparam logic [2:0] FUNCT3_MULH   = 3'b001;
   localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
   localparam logic [2:0] FUNCT3_MULHU  = 3'b011;

   typedef enum logic [1:0] {
      MUL_ST_IDLE = 2'd0,
      MUL_ST_CALC = 2'd1,
      MUL_ST_FIX  = 2'd2,
      MUL_ST_DONE = 2'd3
   } mul_state_t;

   // 0x80000000 stays 0x80000000 and is read as an unsigned magnitude.
   function automatic logic [DATA_BUS_WIDTH-1:0] mag(
      input logic [DATA_BUS_WIDTH-1:0] op,
      input logic                      is_signed
   );
      return (is_signed && op[DATA_BUS_WIDTH-1]) ? -op : op;
   endfunction

endpackage

// File: rtl/mul_ctrl_if.sv
// Request/response and multiplier-side signals of the multiply sequencer.
interface mul_ctrl_if;
   import mul_ctrl_pkg::*;

   // Handshake: a request transfers on a rising edge where mul_valid_i=1,
   // mul_ready_o=1 and flush_i=0; result_valid_o is a one-cycle pulse with
   // result_o valid in that same cycle and has no back-pressure.
   logic                             mul_valid_i;
   logic [2:0]                       funct3_i;
   logic [DATA_BUS_WIDTH-1:0]        op1_i;
   logic [DATA_BUS_WIDTH-1:0]        op2_i;
   logic                             flush_i;
   logic                             mul_ready_o;
   logic                             stall_req_o;
   logic                             mul_en_o;
   logic [DATA_BUS_WIDTH-1:0]        mul_op1_o;
   logic [DATA_BUS_WIDTH-1:0]        mul_op2_o;
   logic [DOUBLE_DATA_BUS_WIDTH-1:0] mul_prod_i;
   logic                             result_valid_o;
   logic [DATA_BUS_WIDTH-1:0]        result_o;
   mul_state_t                       dbg_state;

   modport slave (
      input  mul_valid_i, funct3_i, op1_i, op2_i, flush_i, mul_prod_i,
      output mul_ready_o, stall_req_o, mul_en_o, mul_op1_o, mul_op2_o,
             result_valid_o, result_o, dbg_state
   );

   modport master (
      output mul_valid_i, funct3_i, op1_i, op2_i, flush_i, mul_prod_i,
      input  mul_ready_o, stall_req_o, mul_en_o, mul_op1_o, mul_op2_o,
             result_valid_o, result_o, dbg_state
   );

endinterface

// File: rtl/mul_sign_fix.sv
// Conditional two's-complement negate of the unsigned product, then
// low/high word select.
module mul_sign_fix
   import mul_ctrl_pkg::*;
#(
   parameter int W = DATA_BUS_WIDTH
) (
   input  logic [2*W-1:0] prod,
   input  logic           neg,
   input  logic           hi_sel,
   output logic [W-1:0]   word
);

   logic [2*W-1:0] fixed;

   assign fixed = neg ? ((~prod) + {{(2*W-1){1'b0}}, 1'b1}) : prod;
   assign word  = hi_sel ? fixed[2*W-1:W] : fixed[W-1:0];

endmodule

// File: rtl/mul_ctrl.sv
// EX-stage sequencer for the external 32x32 unsigned array multiplier.
// Optional MUL_ZERO_SKIP_EN: zero operands bypass CALC/FIX with result 0.
module mul_ctrl
   import mul_ctrl_pkg::*;
#(
   parameter int DATA_W  = DATA_BUS_WIDTH,
   parameter int MUL_LAT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   mul_ctrl_if.slave  bus
);

   localparam logic [3:0] CNT_LAST = 4'(MUL_LAT - 1);

   mul_state_t  state;
   logic [3:0]  cnt;
   logic [2:0]  f3_q;
   logic        neg_q;
   logic [DATA_W-1:0] op1_q, op2_q, res_q;
   logic        res_v_q;

   logic        can_accept, accept;
   logic        s1, s2, neg_in;
   logic [2:0]  f3_in;
   logic [DATA_W-1:0] mag1, mag2, fix_word;

   // Undefined funct3[2]=1 encodings are folded onto MULHU.
   assign f3_in      = bus.funct3_i[2] ? FUNCT3_MULHU : bus.funct3_i;
   assign s1         = (f3_in != FUNCT3_MULHU);
   assign s2         = (f3_in == FUNCT3_MUL) || (f3_in == FUNCT3_MULH);
   assign mag1       = mag(bus.op1_i, s1);
   assign mag2       = mag(bus.op2_i, s2);
   assign neg_in     = (s1 & bus.op1_i[DATA_W-1]) ^ (s2 & bus.op2_i[DATA_W-1]);
   assign can_accept = (state == MUL_ST_IDLE) || (state == MUL_ST_DONE);
   assign accept     = bus.mul_valid_i && can_accept && !bus.flush_i;

   mul_sign_fix #(.W(DATA_W)) u_sign_fix (
      .prod   (bus.mul_prod_i),
      .neg    (neg_q),
      .hi_sel (f3_q != FUNCT3_MUL),
      .word   (fix_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= MUL_ST_IDLE;
         cnt     <= '0;
         f3_q    <= '0;
         neg_q   <= 1'b0;
         op1_q   <= '0;
         op2_q   <= '0;
         res_q   <= '0;
         res_v_q <= 1'b0;
      end else if (bus.flush_i) begin
         state   <= MUL_ST_IDLE;
         cnt     <= '0;
         res_v_q <= 1'b0;
      end else begin
         case (state)
            MUL_ST_IDLE, MUL_ST_DONE: begin
               res_v_q <= 1'b0;
               if (accept) begin
                  f3_q  <= f3_in;
                  neg_q <= neg_in;
                  op1_q <= mag1;
                  op2_q <= mag2;
                  cnt   <= '0;
`ifdef MUL_ZERO_SKIP_EN
                  if ((bus.op1_i == '0) || (bus.op2_i == '0)) begin
                     state   <= MUL_ST_DONE;
                     res_q   <= '0;
                     res_v_q <= 1'b1;
                  end else begin
                     state <= MUL_ST_CALC;
                  end
`else
                  state <= MUL_ST_CALC;
`endif
               end else begin
                  state <= MUL_ST_IDLE;
               end
            end
            MUL_ST_CALC: begin
               // The product is a multicycle path; give it MUL_LAT cycles.
               if (cnt == CNT_LAST) state <= MUL_ST_FIX;
               else                 cnt   <= cnt + 4'd1;
            end
            MUL_ST_FIX: begin
               res_q   <= fix_word;
               res_v_q <= 1'b1;
               state   <= MUL_ST_DONE;
            end
            default: state <= MUL_ST_IDLE;
         endcase
      end
   end

   // Stall covers the accept cycle itself, so it carries the accept term.
   assign bus.mul_ready_o    = can_accept;
   assign bus.stall_req_o    = accept || (state == MUL_ST_CALC) || (state == MUL_ST_FIX);
   assign bus.mul_en_o       = (state == MUL_ST_CALC);
   assign bus.mul_op1_o      = op1_q;
   assign bus.mul_op2_o      = op2_q;
   assign bus.result_valid_o = res_v_q;
   assign bus.result_o       = res_q;
   assign bus.dbg_state      = state;

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed, table-driven bench for mul_ctrl; expected latency of zero-operand
// ops follows MUL_ZERO_SKIP_EN.
module tb_mul_ctrl;
   import mul_ctrl_pkg::*;

   localparam int MUL_LAT  = 2;
   localparam int FULL_LAT = MUL_LAT + 2;
`ifdef MUL_ZERO_SKIP_EN
   localparam int ZERO_LAT = 1;
`else
   localparam int ZERO_LAT = FULL_LAT;
`endif

   // clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mul_ctrl_if bus ();

   mul_ctrl #(.DATA_W(32), .MUL_LAT(MUL_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Unsigned array multiplier sitting next to the sequencer
   assign bus.mul_prod_i = {32'b0, bus.mul_op1_o} * {32'b0, bus.mul_op2_o};

   // scoreboard
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a, b, mag_a, mag_b, res;
      int          lat;
      string       name;
   } vec_t;

   vec_t vecs[12];

   // driver tasks: callers sit just after a falling edge
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
      bus.mul_valid_i = 1'b1;
      bus.funct3_i    = f3;
      bus.op1_i       = a;
      bus.op2_i       = b;
      exp_q.push_back(exp);
      #1;
      check("ready_at_accept", bus.mul_ready_o, 1);
      check("stall_at_accept", bus.stall_req_o, 1);
      @(posedge clk);
      @(negedge clk);
      bus.mul_valid_i = 1'b0;
   endtask

   task automatic wait_result(input int exp_lat, input string name);
      int   n = 1;
      logic stall_ok = 1'b1;
      logic [31:0] exp;
      #1;
      while (!bus.result_valid_o && n < 40) begin
         if (!bus.stall_req_o) stall_ok = 1'b0;
         @(negedge clk);
         #1;
         n++;
      end
      check({name, "_valid"}, bus.result_valid_o, 1);
      check({name, "_latency"}, 64'(n), 64'(exp_lat));
      if (exp_q.size() == 0) begin
         check({name, "_scoreboard_empty"}, 1, 0);
      end else begin
         exp = exp_q.pop_front();
         check({name, "_result"}, bus.result_o, exp);
      end
      check({name, "_stall_in_done"}, bus.stall_req_o, 0);
      check({name, "_stall_held"}, stall_ok, 1);
   endtask

   initial begin
      logic saw_valid;

      vecs[0]  = '{FUNCT3_MUL,    32'd7,        32'd6,        32'd7,        32'd6,        32'h0000002A, FULL_LAT, "mul_7x6"};
      vecs[1]  = '{FUNCT3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h00000000, FULL_LAT, "mulh_m1_m1"};
      vecs[2]  = '{FUNCT3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, FULL_LAT, "mulhu_max"};
      vecs[3]  = '{FUNCT3_MULHSU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'h00000003, 32'hFFFFFFFF, FULL_LAT, "mulhsu_m2_3"};
      vecs[4]  = '{FUNCT3_MUL,    32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'h00000003, 32'hFFFFFFFA, FULL_LAT, "mul_m2_3"};
      vecs[5]  = '{FUNCT3_MULH,   32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h40000000, FULL_LAT, "mulh_min_min"};
      vecs[6]  = '{3'b100,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, FULL_LAT, "f3_100_as_mulhu"};
      vecs[7]  = '{FUNCT3_MULH,   32'hFFFFFFFF, 32'h00000005, 32'h00000001, 32'h00000005, 32'hFFFFFFFF, FULL_LAT, "mulh_m1_5"};
      vecs[8]  = '{FUNCT3_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h00000001, FULL_LAT, "mul_m1_m1"};
      vecs[9]  = '{FUNCT3_MULH,   32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, FULL_LAT, "mulh_max_min"};
      vecs[10] = '{FUNCT3_MUL,    32'h00000000, 32'h00000005, 32'h00000000, 32'h00000005, 32'h00000000, ZERO_LAT, "mul_zero_op1"};
      vecs[11] = '{FUNCT3_MULHU,  32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, ZERO_LAT, "mulhu_zero_op2"};

      bus.mul_valid_i = 1'b0;
      bus.funct3_i    = '0;
      bus.op1_i       = '0;
      bus.op2_i       = '0;
      bus.flush_i     = 1'b0;
      rst_n           = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;

      check("rst_ready",   bus.mul_ready_o, 1);
      check("rst_stall",   bus.stall_req_o, 0);
      check("rst_en",      bus.mul_en_o, 0);
      check("rst_rvalid",  bus.result_valid_o, 0);
      check("rst_result",  bus.result_o, 0);
      check("rst_state",   bus.dbg_state, MUL_ST_IDLE);

      // table-driven single operations
      foreach (vecs[i]) begin
         @(negedge clk);
         issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].res);
         check({vecs[i].name, "_mag1"}, bus.mul_op1_o, vecs[i].mag_a);
         check({vecs[i].name, "_mag2"}, bus.mul_op2_o, vecs[i].mag_b);
         check({vecs[i].name, "_mul_en"}, bus.mul_en_o, 64'(vecs[i].lat > 1));
         wait_result(vecs[i].lat, vecs[i].name);
         @(negedge clk);
         #1;
         check({vecs[i].name, "_pulse_1cyc"}, bus.result_valid_o, 0);
      end

      // back-to-back: second request accepted in DONE, no idle bubble
      @(negedge clk);
      issue(FUNCT3_MULH, 32'h80000000, 32'h80000000, 32'h40000000);
      wait_result(FULL_LAT, "b2b_first");
      check("b2b_state_done", bus.dbg_state, MUL_ST_DONE);
      issue(FUNCT3_MULHU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001);
      wait_result(FULL_LAT, "b2b_second");

      // flush during CALC
      @(negedge clk);
      issue(FUNCT3_MULHU, 32'd5, 32'd5, 32'd0);
      void'(exp_q.pop_back());  // this op is aborted, nothing will come back
      check("flush_in_calc", bus.dbg_state, MUL_ST_CALC);
      bus.flush_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.flush_i = 1'b0;
      #1;
      check("flush_state", bus.dbg_state, MUL_ST_IDLE);
      check("flush_stall", bus.stall_req_o, 0);
      check("flush_ready", bus.mul_ready_o, 1);
      saw_valid = 1'b0;
      repeat (FULL_LAT + 2) begin
         @(negedge clk);
         if (bus.result_valid_o) saw_valid = 1'b1;
      end
      check("flush_no_result", saw_valid, 0);
      issue(FUNCT3_MUL, 32'h00001234, 32'h00000010, 32'h00012340);
      wait_result(FULL_LAT, "after_flush");

      // request in the same cycle as flush is dropped
      @(negedge clk);
      bus.mul_valid_i = 1'b1;
      bus.flush_i     = 1'b1;
      bus.funct3_i    = FUNCT3_MUL;
      bus.op1_i       = 32'd3;
      bus.op2_i       = 32'd3;
      #1;
      check("flush_req_stall", bus.stall_req_o, 0);
      @(posedge clk);
      @(negedge clk);
      bus.mul_valid_i = 1'b0;
      bus.flush_i     = 1'b0;
      #1;
      check("flush_req_state", bus.dbg_state, MUL_ST_IDLE);
      check("flush_req_en", bus.mul_en_o, 0);

      // asynchronous reset mid-CALC
      @(negedge clk);
      issue(FUNCT3_MUL, 32'd9, 32'd9, 32'd81);
      void'(exp_q.pop_back());  // reset discards this op
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_state",  bus.dbg_state, MUL_ST_IDLE);
      check("arst_stall",  bus.stall_req_o, 0);
      check("arst_en",     bus.mul_en_o, 0);
      check("arst_rvalid", bus.result_valid_o, 0);
      check("arst_result", bus.result_o, 0);
      check("arst_op1",    bus.mul_op1_o, 0);
      check("arst_op2",    bus.mul_op2_o, 0);
      check("arst_ready",  bus.mul_ready_o, 1);
      @(negedge clk);
      rst_n = 1'b1;
      saw_valid = 1'b0;
      repeat (FULL_LAT + 2) begin
         @(negedge clk);
         if (bus.result_valid_o) saw_valid = 1'b1;
      end
      check("arst_no_result", saw_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
